hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised successor of the decode-stage stall unit: per-register scoreboard of pending writes
//  with per-instruction result latency, so variable-latency producers (mul/div, cache-miss loads)
//  stall dependents for exactly as long as needed. Sits between IF/ID and ID/EX; drives the
//  IF/ID hold and ID/EX bubble. Adds RAW and WAW checks, flush support and a stall counter.
// PARAMETERS
//  NUM_REGS  32  architectural registers; register 0 is hard-wired zero, never pending
//  REG_AW    5   register index width, clog2(NUM_REGS)
//  NUM_SRC   2   source operands checked per instruction
//  LAT_W     3   latency field width; value 2**LAT_W-1 (LAT_WAIT) = "unknown, wait for wb"
//  FWD_DIST  1   remaining count at/below which a result is forwardable (0 = no forwarding)
//  CNT_W     16  stall performance counter width
// PORTS
//  clk           in   1               rising-edge clock
//  rst_n         in   1               asynchronous active-low reset
//  issue_valid   in   1               instruction in ID requests issue
//  issue_we      in   1               instruction writes issue_rd
//  issue_rd      in   REG_AW          destination register
//  issue_lat     in   LAT_W           cycles until result valid; 0 = no scoreboard entry; LAT_WAIT = wait for wb
//  issue_rs      in   NUM_SRC*REG_AW  source registers, src i at [i*REG_AW +: REG_AW]
//  issue_rs_use  in   NUM_SRC         per-source "operand actually read" enable
//  wb_valid      in   1               variable-latency producer completes
//  wb_rd         in   REG_AW          register completed by wb_valid
//  flush         in   1               pipeline redirect: drop all pending entries
//  stall         out  1               hold IF/ID, bubble into ID/EX (combinational)
//  issue_fire    out  1               issue_valid & ~stall & ~flush
//  busy_vec      out  NUM_REGS        registered: bit r = cnt[r]!=0
//  stall_cycles  out  CNT_W           saturating count of cycles with stall=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): all cnt[r]=0, busy_vec=0, stall_cycles=0; stall/issue_fire=0 as
//    issue_valid has no pending entries to hit. Reset mid-operation discards everything pending.
//  - State per register r: cnt[r] in [0..LAT_WAIT]. 0 idle; 1..LAT_WAIT-1 counting; LAT_WAIT parked.
//  - Each cycle: counting entries decrement by 1; parked entries hold until wb_valid && wb_rd==r,
//    then go to 0 next cycle. wb_valid to an idle or counting register is ignored.
//  - RAW: source i hazards if issue_rs_use[i] && rs_i!=0 && cnt[rs_i] > FWD_DIST
//    (parked entries always hazard). FWD_DIST=0 means result must be fully retired.
//  - WAW: hazard if issue_we && rd!=0 && cnt[rd]!=0 && (cnt[rd]==LAT_WAIT || cnt[rd] > issue_lat).
//  - stall = issue_valid & ~flush & (any RAW | WAW). Zero-cycle: same-cycle inputs, no latency.
//  - On issue_fire && issue_we && rd!=0 && issue_lat!=0: cnt[rd] <= issue_lat next cycle.
//  - Same-cycle priority for one register: flush > issue write > wb clear > decrement.
//  - flush=1: every cnt -> 0 next cycle, issue_fire=0, stall=0; issue in that cycle is discarded.
//  - stall_cycles increments when stall=1, saturates at all-ones, cleared only by reset.
//  - Entries never wrap: decrement only when cnt in 1..LAT_WAIT-1.
// STRUCTURE
//  - Shared package hazard_pkg: LAT_WAIT constant function of LAT_W, lat_t typedef, reg index
//    typedef, FWD_DIST default; reused by ID decode to generate issue_lat.
//  - One sub-module sb_entry (one register's counter: load/decrement/park/clear), instanced
//    NUM_REGS-1 times by generate; entry 0 tied to idle. Hazard compare logic stays in top.
// TESTING
//  - Load-use: issue rd=5 lat=2, next cycle rs1=5 use; FWD_DIST=1 -> stall=1 one cycle, then fire.
//  - Divide: rd=7 lat=6, dependent rs2=7 -> stall exactly 5 cycles (cnt 6..2), stall_cycles=5.
//  - Miss load: rd=9 lat=LAT_WAIT, dependent stalls until wb_valid rd=9, fires cycle after wb.
//  - WAW: rd=3 lat=5 pending, issue rd=3 lat=1 -> stall until cnt[3]<=1; lat=6 -> no stall.
//  - x0 and unused src: issue rd=0 lat=4 then rs1=0 -> no stall; rs_use=0 on busy reg -> no stall.
//  - flush during parked rd=9 plus issue same cycle -> issue_fire=0, busy_vec=0 next cycle;
//    rst_n low mid-countdown -> busy_vec=0, stall_cycles=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard definitions. ID decode uses the same
// encoding to build issue_lat.
//   lat_wait(w) : the "unknown latency, wait for writeback" code for a w-bit
//                 latency field. This is the all-ones value.
//   lat_t       : latency field at the default width.
//   reg_idx_t   : architectural register index at the default width.
package hazard_pkg;

  localparam int LAT_W_DEF    = 3;
  localparam int REG_AW_DEF   = 5;
  localparam int FWD_DIST_DEF = 1;

  typedef logic [LAT_W_DEF-1:0]  lat_t;
  typedef logic [REG_AW_DEF-1:0] reg_idx_t;

  function automatic int lat_wait(input int w);
    return (1 << w) - 1;
  endfunction

  localparam lat_t LAT_WAIT_DEF = lat_t'(lat_wait(LAT_W_DEF));

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: pending-write counter for one architectural register.
//   clk, rst_n : clock and asynchronous active-low reset
//   flush      : drop the entry
//   load       : an issuing instruction claims this register
//   load_lat   : latency written by load
//   wb_hit     : a writeback completes this register
//   cnt        : 0 = idle, 1..LAT_WAIT-1 = counting down, LAT_WAIT = parked
//   busy       : cnt != 0
// Priority when several controls are active together:
//   flush > load > wb clear > decrement.
import hazard_pkg::*;

module sb_entry #(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic             wb_hit,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [LAT_W-1:0] LAT_WAIT = LAT_W'(lat_wait(LAT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt <= '0;
    else if (flush)                             cnt <= '0;
    else if (load)                              cnt <= load_lat;
    // A writeback only releases a parked entry. A counting entry
    // retires on its own, so a writeback for it is ignored.
    else if (wb_hit && cnt == LAT_WAIT)         cnt <= '0;
    // Decrement only while counting. This never wraps and never leaves
    // the parked state.
    else if (cnt != '0 && cnt != LAT_WAIT)      cnt <= cnt - LAT_W'(1);
  end

  assign busy = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage stall unit. It keeps a per-register
// scoreboard of pending writes, and each write carries its own result
// latency.
//   clk, rst_n    : clock and asynchronous active-low reset
//   issue_*       : instruction in ID. Fields: valid, writes-rd, rd,
//                   latency, packed sources, per-source use enables.
//   wb_valid/rd   : a variable-latency producer completes register rd
//   flush         : pipeline redirect. Drops all pending entries.
//   stall         : holds IF/ID and bubbles ID/EX. Combinational.
//   issue_fire    : the instruction in ID issues this cycle
//   busy_vec      : bit r set while register r has a pending write.
//                   Derived from flops only.
//   stall_cycles  : saturating count of stalled cycles
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int FWD_DIST = FWD_DIST_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] issue_rs,
  input  logic [NUM_SRC-1:0]        issue_rs_use,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam logic [LAT_W-1:0] LAT_WAIT = LAT_W'(lat_wait(LAT_W));
  localparam logic [LAT_W-1:0] FWD_L    = LAT_W'(FWD_DIST);

  logic [NUM_REGS-1:0][LAT_W-1:0]  cnt;
  logic [NUM_SRC-1:0][REG_AW-1:0]  rs_idx;
  logic [NUM_SRC-1:0]              raw_vec;
  logic                            waw;
  logic                            load_en;
  logic [LAT_W-1:0]                rd_cnt;

  assign rs_idx = issue_rs;

  // RAW check per source. A parked entry always hazards, even when
  // FWD_DIST reaches the parked code.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_raw
    assign raw_vec[i] = issue_rs_use[i] && (rs_idx[i] != '0) &&
                        ((cnt[rs_idx[i]] > FWD_L) || (cnt[rs_idx[i]] == LAT_WAIT));
  end

  // WAW check. The new write must not complete before the pending one.
  assign rd_cnt = cnt[issue_rd];
  assign waw    = issue_we && (issue_rd != '0) && (rd_cnt != '0) &&
                  ((rd_cnt == LAT_WAIT) || (rd_cnt > issue_lat));

  assign stall      = issue_valid && !flush && ((|raw_vec) || waw);
  assign issue_fire = issue_valid && !stall && !flush;
  assign load_en    = issue_fire && issue_we && (issue_rd != '0) && (issue_lat != '0);

  // Register 0 is hard-wired zero and never pending.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    sb_entry #(.LAT_W(LAT_W)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (load_en && (issue_rd == REG_AW'(r))),
      .load_lat (issue_lat),
      .wb_hit   (wb_valid && (wb_rd == REG_AW'(r))),
      .cnt      (cnt[r]),
      .busy     (busy_vec[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cycles <= '0;
    else if (stall && stall_cycles != '1)   stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NR  = 32;
  localparam int LW  = 7;   // LAT_WAIT for 3-bit latency
  localparam int FWD = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_we, wb_valid, flush;
  logic [4:0]  issue_rd, wb_rd;
  logic [2:0]  issue_lat;
  logic [9:0]  issue_rs;
  logic [1:0]  issue_rs_use;
  logic        stall, issue_fire;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .issue_rs(issue_rs), .issue_rs_use(issue_rs_use),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model in absolute time. Each register holds either the
  // cycle at which its result is retired, or a parked flag.
  longint now;
  longint ready [NR];
  bit     parked[NR];
  int     m_scnt;

  function automatic int rem(input int r);
    if (r == 0) return 0;
    if (parked[r]) return LW;
    return (ready[r] > now) ? int'(ready[r] - now) : 0;
  endfunction

  function automatic bit m_stall();
    bit h = 1'b0;
    int rd = int'(issue_rd);
    for (int i = 0; i < 2; i++) begin
      int rs = int'(issue_rs[i*5 +: 5]);
      if (issue_rs_use[i] && rs != 0 && (rem(rs) > FWD || rem(rs) == LW)) h = 1'b1;
    end
    if (issue_we && rd != 0 && rem(rd) != 0 && (rem(rd) == LW || rem(rd) > int'(issue_lat)))
      h = 1'b1;
    return issue_valid && !flush && h;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 0; r < NR; r++) b[r] = (rem(r) != 0);
    return b;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin ready[r] = 0; parked[r] = 1'b0; end
    m_scnt = 0;
  endtask

  task automatic m_update(input bit st);
    bit fire = issue_valid && !st && !flush;
    if (flush) begin
      for (int r = 0; r < NR; r++) begin ready[r] = 0; parked[r] = 1'b0; end
    end else begin
      if (wb_valid && parked[wb_rd]) begin parked[wb_rd] = 1'b0; ready[wb_rd] = now + 1; end
      if (fire && issue_we && issue_rd != 0 && issue_lat != 0) begin
        parked[issue_rd] = (int'(issue_lat) == LW);
        ready[issue_rd]  = now + 1 + longint'(issue_lat);
      end
    end
    if (st && m_scnt < 65535) m_scnt++;
    now++;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One cycle. Sample at the negedge, compare with the model and optionally
  // with fixed expectations, then advance the model at the posedge.
  task automatic tick(input string nm, input bit use_exp, input bit es, input bit ef);
    bit ms;
    @(negedge clk);
    ms = m_stall();
    chk({nm, " stall/model"}, 64'(stall), 64'(ms));
    chk({nm, " fire/model"}, 64'(issue_fire), 64'(issue_valid && !ms && !flush));
    chk({nm, " busy_vec/model"}, 64'(busy_vec), 64'(m_busy()));
    chk({nm, " stall_cycles/model"}, 64'(stall_cycles), 64'(m_scnt));
    if (use_exp) begin
      chk({nm, " stall"}, 64'(stall), 64'(es));
      chk({nm, " fire"}, 64'(issue_fire), 64'(ef));
    end
    @(posedge clk);
    m_update(ms);
    #1;
  endtask

  task automatic set_in(input bit v, input bit we, input int rd, input int lat,
                        input int rs0, input int rs1, input logic [1:0] su);
    issue_valid = v; issue_we = we; issue_rd = 5'(rd); issue_lat = 3'(lat);
    issue_rs = {5'(rs1), 5'(rs0)}; issue_rs_use = su;
  endtask

  typedef struct {
    bit v; bit we; int rd; int lat; int rs0; int rs1; logic [1:0] su;
    bit es; bit ef;
  } vec_t;

  function automatic vec_t mk(input bit v, input bit we, input int rd, input int lat,
                              input int rs0, input int rs1, input logic [1:0] su,
                              input bit es, input bit ef);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.lat = lat; t.rs0 = rs0; t.rs1 = rs1;
    t.su = su; t.es = es; t.ef = ef;
    return t;
  endfunction

  vec_t tbl[22];

  initial begin
    // Load-use: rd5 lat2, then a dependent stalls one cycle.
    tbl[0]  = mk(1,1,5,2, 0,0,2'b00, 0,1);
    tbl[1]  = mk(1,0,0,0, 5,0,2'b01, 1,0);
    tbl[2]  = mk(1,0,0,0, 5,0,2'b01, 0,1);
    // Divide: rd7 lat6, dependent on rs2 stalls while cnt is 6..2.
    tbl[3]  = mk(1,1,7,6, 0,0,2'b00, 0,1);
    for (int i = 4; i <= 8; i++) tbl[i] = mk(1,0,0,0, 0,7,2'b10, 1,0);
    tbl[9]  = mk(1,0,0,0, 0,7,2'b10, 0,1);
    // WAW: rd3 lat5 pending, a second write with lat1 waits until cnt<=1.
    tbl[10] = mk(1,1,3,5, 0,0,2'b00, 0,1);
    for (int i = 11; i <= 14; i++) tbl[i] = mk(1,1,3,1, 0,0,2'b00, 1,0);
    tbl[15] = mk(1,1,3,1, 0,0,2'b00, 0,1);
    tbl[16] = mk(1,1,3,6, 0,0,2'b00, 0,1);   // longer write never waits
    // x0 and unused sources.
    tbl[17] = mk(1,1,0,4, 0,0,2'b00, 0,1);
    tbl[18] = mk(1,0,0,0, 0,0,2'b01, 0,1);
    tbl[19] = mk(1,0,0,0, 3,3,2'b00, 0,1);   // busy reg, rs_use=0
    tbl[20] = mk(1,0,0,0, 3,0,2'b01, 1,0);   // busy reg, used
    tbl[21] = mk(0,0,0,0, 3,0,2'b01, 0,0);   // not valid: no stall

    now = 0;
    m_reset();
    rst_n = 1'b0;
    set_in(0,0,0,0,0,0,2'b00);
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #1;
    chk("reset busy_vec", 64'(busy_vec), 64'd0);
    chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset fire", 64'(issue_fire), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].lat, tbl[i].rs0, tbl[i].rs1, tbl[i].su);
      tick($sformatf("tbl[%0d]", i), 1'b1, tbl[i].es, tbl[i].ef);
    end

    set_in(0,0,0,0,0,0,2'b00);
    repeat (8) tick("idle", 1'b0, 1'b0, 1'b0);

    // Miss load: parked until the writeback, fires the cycle after it.
    set_in(1,1,9,LW, 0,0,2'b00); tick("miss issue", 1'b1, 1'b0, 1'b1);
    set_in(1,0,0,0, 9,0,2'b01);
    repeat (4) tick("miss wait", 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd9; tick("miss wb", 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b0; tick("miss fire", 1'b1, 1'b0, 1'b1);

    // Flush with a parked entry and a same-cycle issue.
    set_in(1,1,9,LW, 0,0,2'b00); tick("flush pre", 1'b1, 1'b0, 1'b1);
    set_in(1,1,4,3, 9,0,2'b01); flush = 1'b1;
    tick("flush", 1'b1, 1'b0, 1'b0);
    flush = 1'b0; set_in(0,0,0,0,0,0,2'b00);
    #3 chk("flush busy_vec", 64'(busy_vec), 64'd0);
    tick("post flush", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a countdown.
    set_in(1,1,7,6, 0,0,2'b00); tick("rst pre", 1'b1, 1'b0, 1'b1);
    set_in(0,0,0,0,0,0,2'b00); tick("rst count", 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0; m_reset();
    #1;
    chk("midrst busy_vec", 64'(busy_vec), 64'd0);
    chk("midrst stall_cycles", 64'(stall_cycles), 64'd0);
    #1 rst_n = 1'b1;
    tick("after rst", 1'b0, 1'b0, 1'b0);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0,3) != 0, $urandom_range(0,1) == 1, $urandom_range(0,7),
             $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7),
             2'($urandom_range(0,3)));
      wb_valid = ($urandom_range(0,3) == 0);
      wb_rd    = 5'($urandom_range(0,7));
      flush    = ($urandom_range(0,39) == 0);
      tick("rand", 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
